// File: rtl/fetch_predictor.sv
// IF-stage PC generator with a direct-mapped, flop-based BTB of 2-bit counters; lookup is combinational on pc.
// Stall holds pc; a misprediction raises flush in the same cycle and overrides stall; the BTB updates one edge after resolution.
module fetch_predictor #(
  parameter int          PC_W        = 9,
  parameter int          BTB_ENTRIES = 16,
  parameter int unsigned RESET_PC    = 0,
  parameter int          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  output logic [PC_W-1:0]   pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              res_valid,
  input  logic [PC_W-1:0]   res_pc,
  input  logic              res_taken,
  input  logic [PC_W-1:0]   res_target,
  input  logic              res_pred_taken,
  input  logic [PC_W-1:0]   res_pred_target,
  output logic              flush,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [PC_W-1:0]        pc_q, pc_d;
  logic [BTB_ENTRIES-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
  logic [PC_W-1:0]        tgt_q [BTB_ENTRIES];
  logic [PC_W-1:0]        tgt_d [BTB_ENTRIES];
  logic [1:0]             cnt_q [BTB_ENTRIES];
  logic [1:0]             cnt_d [BTB_ENTRIES];
  logic [CNT_W-1:0]       mcnt_q, mcnt_d;

  logic [IDX_W-1:0] lk_idx, rs_idx;
  logic [TAG_W-1:0] lk_tag, rs_tag;
  logic             lk_hit, rs_hit;
  logic [PC_W-1:0]  pc_plus4, correct_pc;

  // Lookup always reads the pre-update array, so a same-index update lands next cycle.
  assign lk_idx      = pc_q[IDX_W+1:2];
  assign lk_tag      = pc_q[PC_W-1:IDX_W+2];
  assign pc_plus4    = pc_q + PC_W'(4);
  assign lk_hit      = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && cnt_q[lk_idx][1];
  assign pred_target = lk_hit ? tgt_q[lk_idx] : pc_plus4;

  assign rs_idx = res_pc[IDX_W+1:2];
  assign rs_tag = res_pc[PC_W-1:IDX_W+2];
  assign rs_hit = vld_q[rs_idx] && (tag_q[rs_idx] == rs_tag);

  assign flush = res_valid &&
                 ((res_taken != res_pred_taken) ||
                  (res_taken && (res_target != res_pred_target)));
  assign correct_pc = res_taken ? res_target : (res_pc + PC_W'(4));

  assign pc               = pc_q;
  assign mispredict_count = mcnt_q;

  always_comb begin
    pc_d = pc_plus4;
    if (flush) begin
      pc_d = correct_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    if (res_valid) begin
      if (rs_hit) begin
        if (res_taken) begin
          tgt_d[rs_idx] = res_target;
          if (cnt_q[rs_idx] != 2'd3) begin
            cnt_d[rs_idx] = cnt_q[rs_idx] + 2'd1;
          end
        end else if (cnt_q[rs_idx] != 2'd0) begin
          cnt_d[rs_idx] = cnt_q[rs_idx] - 2'd1;
        end
      end else if (res_taken) begin
        // Allocation or replacement of an aliasing entry starts weakly taken.
        vld_d[rs_idx] = 1'b1;
        tag_d[rs_idx] = rs_tag;
        tgt_d[rs_idx] = res_target;
        cnt_d[rs_idx] = 2'd2;
      end
    end
  end

  always_comb begin
    mcnt_d = mcnt_q;
    if (flush && !(&mcnt_q)) begin
      mcnt_d = mcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= PC_W'(RESET_PC);
      vld_q  <= '0;
      mcnt_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= 2'd1;
      end
    end else begin
      pc_q   <= pc_d;
      vld_q  <= vld_d;
      mcnt_q <= mcnt_d;
      tag_q  <= tag_d;
      tgt_q  <= tgt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_predictor.sv
// Directed bench for fetch_predictor: expectations are queued when stimulus is applied and popped when outputs are sampled.
module tb_fetch_predictor;

  localparam int PC_W  = 9;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic [PC_W-1:0]  pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             res_valid;
  logic [PC_W-1:0]  res_pc;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             res_pred_taken;
  logic [PC_W-1:0]  res_pred_target;
  logic             flush;
  logic [CNT_W-1:0] mispredict_count;

  fetch_predictor #(
    .PC_W(PC_W), .BTB_ENTRIES(16), .RESET_PC(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .flush(flush),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic exp_v(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input logic [PC_W-1:0] rpc, input logic tk, input logic [PC_W-1:0] tgt,
                     input logic ptk, input logic [PC_W-1:0] ptgt);
    res_valid       = 1'b1;
    res_pc          = rpc;
    res_taken       = tk;
    res_target      = tgt;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  // Mispredicted resolution whose outcome is expected to flush; checks flush, next pc and count.
  task automatic flush_step(input string tag, input logic [31:0] npc, input logic [31:0] ncnt);
    #1;
    exp_v({tag, "_flush"}, 32'd1);
    chk(32'(flush));
    exp_v({tag, "_pc"}, npc);
    exp_v({tag, "_cnt"}, ncnt);
    tick();
    res_valid = 1'b0;
    chk(32'(pc));
    chk(32'(mispredict_count));
  endtask

  // Resolve (dest-4) as not-taken while it was predicted taken: flush steers pc to dest.
  task automatic redirect(input logic [PC_W-1:0] dest, input logic [31:0] ncnt);
    res(dest - PC_W'(4), 1'b0, dest, 1'b1, dest);
    flush_step("redirect", 32'(dest), ncnt);
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] tk, input logic [31:0] tgt);
    exp_v({tag, "_pred_taken"}, tk);
    exp_v({tag, "_pred_target"}, tgt);
    chk(32'(pred_taken));
    chk(32'(pred_target));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
    res_target = '0; res_pred_taken = 1'b0; res_pred_target = '0;
    #11;
    exp_v("rst_pc", 32'h0);
    exp_v("rst_flush", 32'h0);
    exp_v("rst_cnt", 32'h0);
    chk(32'(pc));
    chk(32'(flush));
    chk(32'(mispredict_count));
    chk_pred("rst", 32'd0, 32'h4);
    reset = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      exp_v("seq_pc", 32'(i * 4));
      exp_v("seq_pred", 32'd0);
      tick();
      chk(32'(pc));
      chk(32'(pred_taken));
    end

    // First taken branch at 0x20 mispredicts and allocates an entry.
    res(9'h020, 1'b1, 9'h080, 1'b0, 9'h024);
    flush_step("alloc", 32'h80, 32'd1);
    redirect(9'h020, 32'd2);
    chk_pred("learned", 32'd1, 32'h80);
    exp_v("follow_pred_pc", 32'h80);
    tick();
    chk(32'(pc));

    // Correct taken resolutions push the counter to 3.
    res(9'h020, 1'b1, 9'h080, 1'b1, 9'h080);
    #1;
    exp_v("train_flush", 32'd0);
    chk(32'(flush));
    exp_v("train_pc", 32'h88);
    exp_v("train_cnt", 32'd2);
    tick();
    tick();
    res_valid = 1'b0;
    chk(32'(pc));
    chk(32'(mispredict_count));

    res(9'h020, 1'b0, 9'h024, 1'b1, 9'h080);
    flush_step("nt_mispred", 32'h24, 32'd3);
    redirect(9'h020, 32'd4);
    chk_pred("cnt2", 32'd1, 32'h80);

    // Update on the index being looked up: lookup still shows the old counter.
    res(9'h020, 1'b0, 9'h024, 1'b1, 9'h080);
    #1;
    chk_pred("same_cycle", 32'd1, 32'h80);
    flush_step("same_cycle", 32'h24, 32'd5);
    redirect(9'h020, 32'd6);
    chk_pred("cnt1", 32'd0, 32'h80);

    redirect(9'h010, 32'd7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_v("stall_pc", 32'h10);
      tick();
      chk(32'(pc));
    end
    res(9'h010, 1'b1, 9'h040, 1'b0, 9'h014);
    flush_step("flush_over_stall", 32'h40, 32'd8);
    stall = 1'b0;

    // 0x04 and 0x44 share index 1 with different tags.
    res(9'h004, 1'b1, 9'h040, 1'b0, 9'h008);
    flush_step("alias_a", 32'h40, 32'd9);
    res(9'h044, 1'b1, 9'h100, 1'b0, 9'h048);
    flush_step("alias_b", 32'h100, 32'd10);
    redirect(9'h004, 32'd11);
    chk_pred("alias_evicted", 32'd0, 32'h8);
    redirect(9'h044, 32'd12);
    chk_pred("alias_new", 32'd1, 32'h100);

    // Taken with correct direction but wrong target still flushes.
    res(9'h1F0, 1'b1, 9'h1FC, 1'b1, 9'h1F8);
    flush_step("tgt_mispred", 32'h1FC, 32'd13);
    chk_pred("wrap", 32'd0, 32'h0);
    exp_v("wrap_pc", 32'h0);
    tick();
    chk(32'(pc));

    redirect(9'h044, 32'd14);
    redirect(9'h044, 32'd15);
    redirect(9'h044, 32'd15);
    chk_pred("pre_reset", 32'd1, 32'h100);

    #2;
    reset = 1'b0;
    res(9'h020, 1'b1, 9'h080, 1'b0, 9'h024);
    #1;
    exp_v("midrst_pc", 32'h0);
    exp_v("midrst_cnt", 32'h0);
    exp_v("midrst_flush", 32'd1);
    chk(32'(pc));
    chk(32'(mispredict_count));
    chk(32'(flush));
    chk_pred("midrst", 32'd0, 32'h4);
    res_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_v("post_rst_pc", 32'h4);
    tick();
    chk(32'(pc));
    redirect(9'h044, 32'd1);
    chk_pred("post_rst_cleared", 32'd0, 32'h48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
